// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the 5-stage pipeline sequencing
//               controller: RV32I opcodes, per-stage destination/source record,
//               forwarding select encoding and the register-match helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_R_I    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wen;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
    } stage_rec_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_M  = 2'd1,
        FWD_W  = 2'd2
    } fwd_sel_t;

    // A consumer source matches a producer only if the producer is live and
    // writes that register. wen is never set for rd==x0, so x0 cannot match.
    function automatic logic rec_match(input logic       use_n,
                                       input logic [4:0] rs,
                                       input stage_rec_t prod);
        return use_n & prod.valid & prod.wen & (prod.rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/insn_reg_decode.sv
`default_nettype none
// ============================================================================
// Module      : insn_reg_decode
// Description : Combinational register-usage decode of one RV32I instruction.
//   i_instruction  in  32  instruction word
//   o_rs1/o_rs2    out 5   source register fields
//   o_rd           out 5   destination register field
//   o_use1/o_use2  out 1   instruction reads rs1 / rs2
//   o_wen          out 1   instruction writes a non-zero rd
//   o_is_load      out 1   instruction is a load
// Revision    : 1.0 - initial release
// ============================================================================
module insn_reg_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] i_instruction,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic        o_use1,
    output logic        o_use2,
    output logic        o_wen,
    output logic        o_is_load
);

    logic [6:0] w_opcode;
    logic       w_writes;
    logic       w_unused_fields;

    assign w_opcode        = i_instruction[6:0];
    assign o_rd            = i_instruction[11:7];
    assign o_rs1           = i_instruction[19:15];
    assign o_rs2           = i_instruction[24:20];
    assign w_unused_fields = ^{i_instruction[31:25], i_instruction[14:12]};

    always_comb begin
        o_use1    = 1'b0;
        o_use2    = 1'b0;
        w_writes  = 1'b0;
        o_is_load = 1'b0;
        case (w_opcode)
            c_OP_R:      begin o_use1 = 1'b1; o_use2 = 1'b1; w_writes = 1'b1; end
            c_OP_R_I:    begin o_use1 = 1'b1; w_writes = 1'b1; end
            c_OP_LOAD:   begin o_use1 = 1'b1; w_writes = 1'b1; o_is_load = 1'b1; end
            c_OP_STORE:  begin o_use1 = 1'b1; o_use2 = 1'b1; end
            c_OP_BRANCH: begin o_use1 = 1'b1; o_use2 = 1'b1; end
            c_OP_JALR:   begin o_use1 = 1'b1; w_writes = 1'b1; end
            c_OP_JAL:    w_writes = 1'b1;
            c_OP_LUI:    w_writes = 1'b1;
            c_OP_AUIPC:  w_writes = 1'b1;
            default:     ;
        endcase
    end

    assign o_wen = w_writes & (o_rd != 5'd0);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall / kill / bubble sequencing and operand-forwarding select
//               generation for a 5-stage (F D E M W) RV32I pipeline. Tracks the
//               register records of the instructions in E, M and W.
//   clock, reset            core clock, synchronous active-high reset
//   d_valid, d_instruction  live instruction in D
//   e_br_taken, e_jp_taken  redirect resolved in E
//   m_mem_busy              data memory not ready, freezes the pipe
//   f_stall, d_stall        hold PC/F->D and D->E registers
//   f_kill, e_bubble        squash F->D, inject bubble into D->E
//   e/m/w_valid             stage valid bits
//   fwd_sel_1, fwd_sel_2    E operand source (0 RF, 1 M, 2 W)
//   stall_count            hazard-stall cycle counter (wraps)
// Build option: PIPE_CTRL_FORWARDING_EN enables M/W forwarding; only
//               load-use against E stalls. Without it any RAW against
//               E/M/W stalls and the forwarding selects are held at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        d_valid,
    input  logic [31:0] d_instruction,
    input  logic        e_br_taken,
    input  logic        e_jp_taken,
    input  logic        m_mem_busy,
    output logic        f_stall,
    output logic        d_stall,
    output logic        f_kill,
    output logic        e_bubble,
    output logic        e_valid,
    output logic        m_valid,
    output logic        w_valid,
    output logic [1:0]  fwd_sel_1,
    output logic [1:0]  fwd_sel_2,
    output logic [31:0] stall_count
);

    stage_rec_t  r_e;
    stage_rec_t  r_m;
    stage_rec_t  r_w;
    logic [31:0] r_stall_count;

    stage_rec_t  w_d;
    stage_rec_t  w_e_next;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic        w_use1;
    logic        w_use2;
    logic        w_wen;
    logic        w_is_load;
    logic        w_raw;
    logic        w_redirect;
    logic        w_hazard;
    logic        w_count_en;
    fwd_sel_t    w_fwd1;
    fwd_sel_t    w_fwd2;
    logic        w_unused_rec;

    insn_reg_decode u_decode (
        .i_instruction (d_instruction),
        .o_rs1         (w_rs1),
        .o_rs2         (w_rs2),
        .o_rd          (w_rd),
        .o_use1        (w_use1),
        .o_use2        (w_use2),
        .o_wen         (w_wen),
        .o_is_load     (w_is_load)
    );

    always_comb begin
        w_d         = '0;
        w_d.valid   = d_valid;
        w_d.rd      = w_rd;
        w_d.wen     = w_wen;
        w_d.is_load = w_is_load;
        w_d.rs1     = w_rs1;
        w_d.rs2     = w_rs2;
        w_d.use1    = w_use1;
        w_d.use2    = w_use2;
    end

`ifdef PIPE_CTRL_FORWARDING_EN
    // Everything except a load result still in E can be forwarded.
    assign w_raw = r_e.is_load &
                   (rec_match(w_d.use1, w_d.rs1, r_e) | rec_match(w_d.use2, w_d.rs2, r_e));

    always_comb begin
        w_fwd1 = FWD_RF;
        w_fwd2 = FWD_RF;
        if (rec_match(r_e.use1, r_e.rs1, r_m))      w_fwd1 = FWD_M;
        else if (rec_match(r_e.use1, r_e.rs1, r_w)) w_fwd1 = FWD_W;
        if (rec_match(r_e.use2, r_e.rs2, r_m))      w_fwd2 = FWD_M;
        else if (rec_match(r_e.use2, r_e.rs2, r_w)) w_fwd2 = FWD_W;
    end
`else
    // Register file is read-before-write, so even a W producer conflicts.
    assign w_raw = rec_match(w_d.use1, w_d.rs1, r_e) | rec_match(w_d.use2, w_d.rs2, r_e) |
                   rec_match(w_d.use1, w_d.rs1, r_m) | rec_match(w_d.use2, w_d.rs2, r_m) |
                   rec_match(w_d.use1, w_d.rs1, r_w) | rec_match(w_d.use2, w_d.rs2, r_w);

    assign w_fwd1 = FWD_RF;
    assign w_fwd2 = FWD_RF;
`endif

    assign w_redirect = e_br_taken | e_jp_taken;
    assign w_hazard   = d_valid & w_raw;

    always_comb begin
        f_stall    = 1'b0;
        d_stall    = 1'b0;
        f_kill     = 1'b0;
        e_bubble   = 1'b0;
        w_count_en = 1'b0;
        if (m_mem_busy) begin
            f_stall = 1'b1;
            d_stall = 1'b1;
        end else if (w_redirect) begin
            // D holds a wrong-path instruction, so its hazard is irrelevant.
            f_kill   = 1'b1;
            e_bubble = 1'b1;
        end else if (w_hazard) begin
            f_stall    = 1'b1;
            d_stall    = 1'b1;
            e_bubble   = 1'b1;
            w_count_en = 1'b1;
        end
    end

    // Bubbles are loaded as all-zero records so no stale source fields can
    // drive the forwarding selects.
    assign w_e_next = (d_valid & ~e_bubble) ? w_d : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_e           <= '0;
            r_m           <= '0;
            r_w           <= '0;
            r_stall_count <= '0;
        end else if (!m_mem_busy) begin
            r_w <= r_m;
            r_m <= r_e;
            r_e <= w_e_next;
            if (w_count_en) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    // Source fields of M/W (and of E without forwarding) are carried only to
    // keep one record type across stages.
    assign w_unused_rec = ^{r_e.is_load, r_e.rs1, r_e.rs2, r_e.use1, r_e.use2,
                            r_m.is_load, r_m.rs1, r_m.rs2, r_m.use1, r_m.use2,
                            r_w.is_load, r_w.rs1, r_w.rs2, r_w.use1, r_w.use2};

    assign e_valid     = r_e.valid;
    assign m_valid     = r_m.valid;
    assign w_valid     = r_w.valid;
    assign fwd_sel_1   = w_fwd1;
    assign fwd_sel_2   = w_fwd2;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32I core (F, D, E, M, W). It tracks the destination-register records of the instructions in E, M and W. From these records it generates the stall, kill and bubble controls and the operand-forwarding selects that feed the execute stage. It also consumes the execute stage's branch/jump resolution to squash wrong-path instructions.

## Interface
- Parameters: none.
- clock  in  1  core clock.
- reset  in  1  reset, synchronous, active-high.
- d_valid  in  1  D-stage pipe register holds a live instruction.
- d_instruction  in  32  instruction currently in D.
- e_br_taken  in  1  execute stage: conditional branch taken (already gated by E valid).
- e_jp_taken  in  1  execute stage: JAL/JALR taken.
- m_mem_busy  in  1  data memory not ready; freeze the whole pipeline.
- f_stall  out  1  hold PC and the F→D register.
- d_stall  out  1  hold the D→E register.
- f_kill  out  1  clear the F→D register valid on the next edge.
- e_bubble  out  1  load a bubble (valid=0) into the D→E register on the next edge.
- e_valid, m_valid, w_valid  out  1 each  stage valid bits.
- fwd_sel_1, fwd_sel_2  out  2 each  E operand source: 0 = register file, 1 = M result, 2 = W result.
- stall_count  out  32  count of hazard-stall cycles; wraps.

## Operation
- Each stage record holds: valid, rd[4:0], wen, is_load, rs1[4:0], rs2[4:0], use1, use2.
- Decode of d_instruction by opcode:
  - use1 for R, R_I, JALR, LOAD, STORE, BRANCH.
  - use2 for R, STORE, BRANCH.
  - wen for R, R_I, LOAD, JALR, JAL, LUI, AUIPC, and only when rd≠0.
  - Any other opcode: use1=use2=wen=0.
- A register match requires use_n, the producer's wen, rd==rs_n, and the producer's valid.
- Control priority, highest first:
  1. m_mem_busy:
     - f_stall=d_stall=1, f_kill=e_bubble=0.
     - All records hold.
     - stall_count does not increment.
  2. Redirect (e_br_taken|e_jp_taken):
     - f_kill=1, e_bubble=1, f_stall=d_stall=0.
     - Any hazard in D is ignored because D is squashed.
  3. Hazard (d_valid and a match per the Configuration rules):
     - f_stall=d_stall=1, e_bubble=1.
     - stall_count increments.
  4. Otherwise all controls are 0.
- Record advance on each non-frozen edge:
  - W←M, M←E.
  - E←D decode, with valid=d_valid&~e_bubble.
- Forwarding, evaluated for the E record:
  - fwd_sel_n=1 if M matches rs_n.
  - Else 2 if W matches.
  - Else 0.
  - M has priority over W. x0 is never forwarded.
- Reset: all record valids are 0.

## Timing
- All control outputs and fwd_sel are combinational from the current records and inputs. They are valid in the same cycle.
- Records and stall_count update on the rising edge of clock only.
- Reset values: all outputs 0; stall_count 0.
- Reset asserted mid-stall or mid-freeze clears everything on the next edge. It has priority over m_mem_busy.
- Load-use stall length is exactly 1 cycle with forwarding (per Configuration).
- m_mem_busy arriving during a hazard stall:
  - Freeze wins.
  - The hazard stall resumes after release with its count unchanged.

## Configuration
- PIPE_CTRL_FORWARDING_EN defined:
  - Hazard = match against E where E.is_load=1.
  - fwd_sel is computed as described in Operation.
- PIPE_CTRL_FORWARDING_EN undefined:
  - Hazard = match against any of E, M or W. The register file is read-before-write, so W conflicts.
  - fwd_sel_1=fwd_sel_2=0 constantly.
  - RAW stall lasts up to 3 cycles.

## Structure
- Package pipe_ctrl_pkg:
  - opcode constants.
  - stage_rec_t struct.
  - fwd_sel_t enum (FWD_RF, FWD_M, FWD_W).
- Sub-module insn_reg_decode: combinational decode of d_instruction into rs1, rs2, rd, use1, use2, wen, is_load.

## Test plan
- FORWARDING_EN, lw x5,0(x1) in E, add x6,x5,x2 in D:
  - f_stall=d_stall=e_bubble=1 for 1 cycle; stall_count=1.
  - When add reaches E: fwd_sel_1=2, fwd_sel_2=0.
- FORWARDING_EN, add x3,x1,x2 in E, sub x4,x3,x3 in D:
  - No stall.
  - Next cycle: fwd_sel_1=fwd_sel_2=1.
- e_br_taken=1 while lw x5 is in E and D reads x5:
  - f_kill=1, e_bubble=1, f_stall=0.
  - stall_count unchanged.
- m_mem_busy=1 for 3 cycles with valid E/M/W:
  - f_stall=d_stall=1.
  - e/m/w_valid and fwd_sel held.
  - stall_count unchanged.
- lw x0,0(x1) in E, add x6,x0,x0 in D: no stall, fwd_sel=0.
- Without FORWARDING_EN, addi x1,x0,5 in E, add x2,x1,x1 in D:
  - Stall for 3 cycles, then issue.
  - stall_count=3.
